// File: rtl/mapa_render.sv
// Snake-game tile map (2-bit cells) with an update read/write port and 640x480@60 VGA scanout of 16x16 tiles.
// Optional: define MAPA_GRID_LINES_EN to overlay 202020 grid lines on empty tiles.
module mapa_render #(
   parameter int MAPA_WIDTH  = 40,
   parameter int MAPA_HEIGHT = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       update_wenable,
   input  logic [1:0] update_wdata,
   input  logic [9:0] update_wx,
   input  logic [9:0] update_wy,
   input  logic       update_renable,
   input  logic [9:0] update_rx,
   input  logic [9:0] update_ry,
   output logic [1:0] update_rdata,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_sync_n,
   output logic       vga_clk,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b
);
   localparam int DEPTH = MAPA_WIDTH * MAPA_HEIGHT;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [9:0]  W10 = 10'(MAPA_WIDTH);
   localparam logic [9:0]  H10 = 10'(MAPA_HEIGHT);
   localparam logic [19:0] W20 = 20'(MAPA_WIDTH);

   typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} ras_state_t;

   logic [1:0] mem [DEPTH];

   logic          w_ok, r_ok, s_ok;
   logic [AW-1:0] waddr, raddr, saddr;
   logic [9:0]    tile_x, tile_y;

   logic          pix_en_q;
   logic [9:0]    hc_q, vc_q, hc_d, vc_d;
   ras_state_t    hst_q, vst_q;
   logic [1:0]    cell_q;
   logic          vis1_q, hs1_q, vs1_q;
   logic          hs_q, vs_q, blank_n_q;
   logic [23:0]   rgb_q, rgb_d;
   logic [1:0]    rdata_q;
`ifdef MAPA_GRID_LINES_EN
   logic          grid1_q;
`endif

   assign w_ok  = (update_wx < W10) && (update_wy < H10);
   assign r_ok  = (update_rx < W10) && (update_ry < H10);
   assign waddr = AW'(20'(update_wy) * W20 + 20'(update_wx));
   assign raddr = AW'(20'(update_ry) * W20 + 20'(update_rx));

   // Blanking-area tile coordinates can run past the grid; those reads are suppressed.
   assign tile_x = {4'b0, hc_q[9:4]};
   assign tile_y = {5'b0, vc_q[8:4]};
   assign s_ok   = (tile_x < W10) && (tile_y < H10);
   assign saddr  = AW'(20'(tile_y) * W20 + 20'(tile_x));

   assign hc_d = (hc_q == 10'd799) ? 10'd0 : hc_q + 10'd1;
   assign vc_d = (vc_q == 10'd524) ? 10'd0 : vc_q + 10'd1;

   always_ff @(posedge clk) begin
      if (update_wenable && w_ok) begin
         mem[waddr] <= update_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= 2'b00;
      end else if (update_renable) begin
         rdata_q <= r_ok ? mem[raddr] : 2'b00;
      end
   end

   always_comb begin
      rgb_d = 24'h000000;
      if (vis1_q) begin
         case (cell_q)
            2'b01:   rgb_d = 24'h00FF00;
            2'b10:   rgb_d = 24'hFF0000;
            2'b11:   rgb_d = 24'h808080;
`ifdef MAPA_GRID_LINES_EN
            default: rgb_d = grid1_q ? 24'h202020 : 24'h000000;
`else
            default: rgb_d = 24'h000000;
`endif
         endcase
      end
   end

   // Raster counters, H/V state machines and the two-tick scanout pipeline.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_en_q  <= 1'b0;
         hc_q      <= 10'd0;
         vc_q      <= 10'd0;
         hst_q     <= ST_ACTIVE;
         vst_q     <= ST_ACTIVE;
         cell_q    <= 2'b00;
         vis1_q    <= 1'b0;
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         rgb_q     <= 24'h000000;
`ifdef MAPA_GRID_LINES_EN
         grid1_q   <= 1'b0;
`endif
      end else begin
         pix_en_q <= ~pix_en_q;
         if (pix_en_q) begin
            hc_q <= hc_d;
            case (hst_q)
               ST_ACTIVE: if (hc_q == 10'd639) hst_q <= ST_FRONT;
               ST_FRONT:  if (hc_q == 10'd655) hst_q <= ST_SYNC;
               ST_SYNC:   if (hc_q == 10'd751) hst_q <= ST_BACK;
               default:   if (hc_q == 10'd799) hst_q <= ST_ACTIVE;
            endcase
            if (hc_q == 10'd799) begin
               vc_q <= vc_d;
               case (vst_q)
                  ST_ACTIVE: if (vc_q == 10'd479) vst_q <= ST_FRONT;
                  ST_FRONT:  if (vc_q == 10'd489) vst_q <= ST_SYNC;
                  ST_SYNC:   if (vc_q == 10'd491) vst_q <= ST_BACK;
                  default:   if (vc_q == 10'd524) vst_q <= ST_ACTIVE;
               endcase
            end
            cell_q    <= s_ok ? mem[saddr] : 2'b00;
            vis1_q    <= (hst_q == ST_ACTIVE) && (vst_q == ST_ACTIVE);
            hs1_q     <= (hst_q != ST_SYNC);
            vs1_q     <= (vst_q != ST_SYNC);
`ifdef MAPA_GRID_LINES_EN
            grid1_q   <= (hc_q[3:0] == 4'd0) || (vc_q[3:0] == 4'd0);
`endif
            hs_q      <= hs1_q;
            vs_q      <= vs1_q;
            blank_n_q <= vis1_q;
            rgb_q     <= rgb_d;
         end
      end
   end

   assign update_rdata = rdata_q;
   assign vga_hs       = hs_q;
   assign vga_vs       = vs_q;
   assign vga_blank_n  = blank_n_q;
   assign vga_sync_n   = 1'b0;
   assign vga_clk      = pix_en_q;
   assign vga_r        = rgb_q[23:16];
   assign vga_g        = rgb_q[15:8];
   assign vga_b        = rgb_q[7:0];
endmodule

// File: tb/tb_mapa_render.sv
// Bench for mapa_render: scoreboarded update reads and scanout pixels against a tile-map reference model.
module tb_mapa_render;
   localparam int W = 40;
   localparam int H = 30;
   localparam int CHECK_LINES = 34;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       update_wenable = 1'b0;
   logic [1:0] update_wdata = 2'b00;
   logic [9:0] update_wx = '0, update_wy = '0;
   logic       update_renable = 1'b0;
   logic [9:0] update_rx = '0, update_ry = '0;
   logic [1:0] update_rdata;
   logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;
   logic [7:0] vga_r, vga_g, vga_b;

   always #10 clk = ~clk;

   mapa_render #(.MAPA_WIDTH(W), .MAPA_HEIGHT(H)) dut (
      .clk(clk), .reset(reset),
      .update_wenable(update_wenable), .update_wdata(update_wdata),
      .update_wx(update_wx), .update_wy(update_wy),
      .update_renable(update_renable), .update_rx(update_rx), .update_ry(update_ry),
      .update_rdata(update_rdata),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
      .vga_clk(vga_clk), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [1:0]  shadow [W*H];
   logic [1:0]  rd_q [$];
   logic [23:0] pix_q [$];
   bit          check_pix = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] model_read(input int x, input int y);
      if (x < W && y < H) return shadow[y*W + x];
      return 2'b00;
   endfunction

   function automatic logic [23:0] model_pixel(input int x, input int y);
      logic [1:0] c;
      c = shadow[(y/16)*W + x/16];
      if (c == 2'b01) return 24'h00FF00;
      if (c == 2'b10) return 24'hFF0000;
      if (c == 2'b11) return 24'h808080;
`ifdef MAPA_GRID_LINES_EN
      if (x % 16 == 0 || y % 16 == 0) return 24'h202020;
`endif
      return 24'h000000;
   endfunction

   // One update-port cycle; the read expectation is taken before the write lands.
   task automatic op(input bit we, input logic [1:0] wd, input int wx, input int wy,
                     input bit re, input int rx, input int ry);
      update_wenable = we;  update_wdata = wd;
      update_wx = 10'(wx);  update_wy = 10'(wy);
      update_renable = re;
      update_rx = 10'(rx);  update_ry = 10'(ry);
      if (re) rd_q.push_back(model_read(rx, ry));
      if (we && wx < W && wy < H) shadow[wy*W + wx] = wd;
      @(posedge clk); #1;
      update_wenable = 1'b0;
      update_renable = 1'b0;
   endtask

   // Read-data monitor
   bit         ren_prev = 1'b0;
   logic [1:0] hold_exp = 2'b00;
   always @(posedge clk) ren_prev <= reset & update_renable;

   always @(negedge clk) begin
      logic [1:0] e;
      if (!reset) begin
         hold_exp = 2'b00;
      end else if (ren_prev) begin
         if (rd_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_queue: read data presented with no expectation, got %0h", update_rdata);
         end else begin
            e = rd_q.pop_front();
            chk("rdata", 32'(update_rdata), 32'(e));
            hold_exp = e;
         end
      end else begin
         chk("rdata_hold", 32'(update_rdata), 32'(hold_exp));
      end
   end

   // Video monitor: one sample per pixel, position derived from blank_n/hs edges
   int px = -1, line_cnt = 0, hs_low = 0, blank_len = 0;
   bit prev_blank = 1'b0, prev_hs = 1'b1;
   always @(negedge clk) begin
      logic [23:0] rgb, e;
      if (!reset) begin
         px = -1; line_cnt = 0; hs_low = 0; blank_len = 0;
         prev_blank = 1'b0; prev_hs = 1'b1;
      end else if (!vga_clk) begin
         rgb = {vga_r, vga_g, vga_b};
         if (vga_blank_n && !prev_blank) begin
            if (line_cnt > 0) chk("line_period", px + 1, 800);
            chk("vs_high", 32'(vga_vs), 1);
            px = 0; line_cnt++; blank_len = 0;
         end else if (px >= 0) begin
            px++;
         end
         if (vga_blank_n) begin
            blank_len++;
            if (check_pix && pix_q.size() > 0) begin
               e = pix_q.pop_front();
               chk("pixel", 32'(rgb), 32'(e));
            end
         end else begin
            if (prev_blank) chk("blank_width", blank_len, 640);
            chk("rgb_outside", 32'(rgb), 0);
         end
         if (!vga_hs && prev_hs) begin
            if (px >= 0) chk("hs_fall_pos", px, 656);
            hs_low = 0;
         end
         if (!vga_hs) hs_low++;
         else if (!prev_hs) chk("hs_low_width", hs_low, 96);
         prev_blank = vga_blank_n;
         prev_hs = vga_hs;
      end
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hs", 32'(vga_hs), 1);
      chk("rst_vs", 32'(vga_vs), 1);
      chk("rst_blank_n", 32'(vga_blank_n), 0);
      chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
      chk("rst_rdata", 32'(update_rdata), 0);
      chk("rst_sync_n", 32'(vga_sync_n), 0);
      chk("rst_vga_clk", 32'(vga_clk), 0);
      reset = 1'b1;

      for (int i = 0; i < W*H; i++) op(1'b1, 2'($urandom_range(0, 3)), i % W, i / W, 1'b0, 0, 0);

      op(1'b1, 2'b10, 5, 3, 1'b0, 0, 0);
      op(1'b0, 2'b00, 0, 0, 1'b1, 5, 3);
      op(1'b1, 2'b01, 5, 3, 1'b1, 5, 3);
      op(1'b0, 2'b00, 0, 0, 1'b1, 5, 3);
      op(1'b1, 2'b11, 41, 3, 1'b0, 0, 0);
      op(1'b0, 2'b00, 0, 0, 1'b1, 41, 3);
      op(1'b0, 2'b00, 0, 0, 1'b1, 1, 3);
      op(1'b0, 2'b00, 0, 0, 1'b1, 9, 4);

      for (int i = 0; i < 300; i++) begin
         int wx, wy, rx, ry;
         wx = ($urandom_range(0, 15) == 0) ? 1023 : int'($urandom_range(0, 47));
         wy = int'($urandom_range(0, 35));
         rx = int'($urandom_range(0, 47));
         ry = int'($urandom_range(0, 35));
         if ($urandom_range(0, 3) == 0) begin rx = wx; ry = wy; end
         op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), wx, wy,
            1'($urandom_range(0, 1)), rx, ry);
         if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
      end

      op(1'b1, 2'b01, 0, 0, 1'b0, 0, 0);
      op(1'b1, 2'b00, 2, 2, 1'b0, 0, 0);
      op(1'b1, 2'b01, 3, 2, 1'b0, 0, 0);
      op(1'b1, 2'b10, 39, 0, 1'b0, 0, 0);
      op(1'b1, 2'b11, 39, 29, 1'b0, 0, 0);
      op(1'b0, 2'b00, 0, 0, 1'b1, 39, 29);
      op(1'b0, 2'b00, 0, 0, 1'b1, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rd_queue_drained", rd_q.size(), 0);

      // Reset in the middle of a visible line
      t = 0;
      while (vga_blank_n && t < 2000) begin @(posedge clk); #1; t++; end
      while (!vga_blank_n && t < 4000) begin @(posedge clk); #1; t++; end
      repeat (600) @(posedge clk);
      #1;
      chk("pre_reset_blank_n", 32'(vga_blank_n), 1);
      reset = 1'b0;
      #1;
      chk("midrst_hs", 32'(vga_hs), 1);
      chk("midrst_vs", 32'(vga_vs), 1);
      chk("midrst_blank_n", 32'(vga_blank_n), 0);
      chk("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
      chk("midrst_rdata", 32'(update_rdata), 0);
      chk("midrst_vga_clk", 32'(vga_clk), 0);
      repeat (4) @(posedge clk);
      #1;

      for (int y = 0; y < CHECK_LINES; y++)
         for (int x = 0; x < 640; x++) pix_q.push_back(model_pixel(x, y));
      check_pix = 1'b1;
      reset = 1'b1;

      t = 0;
      while (pix_q.size() > 0 && t < 60000) begin @(posedge clk); t++; end
      if (pix_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL pixel_timeout: %0d pixels never shown, expected 0 left", pix_q.size());
      end
      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mapa_render.md
# mapa_render

Tile-map storage and VGA scanout for the snake game. Holds the MAPA_WIDTH×MAPA_HEIGHT grid of 2-bit cells. `update` writes and reads the grid through its `update_*` ports. The block continuously scans the grid out as 640×480@60 Hz video with 16×16-pixel tiles. It is the far end of the `update` write/read interface and drives the board's VGA DAC pins.

## Interface
- `MAPA_WIDTH`, default 40: tiles per row.
- `MAPA_HEIGHT`, default 30: tiles per column.
- `clk`  in  1  system clock, 50 MHz; pixel rate is clk/2.
- `reset`  in  1  asynchronous, active-low reset.
- `update_wenable`  in  1  write strobe, one cell per cycle.
- `update_wdata`  in  2  cell value: 00 empty, 01 snake, 10 fruit, 11 obstacle.
- `update_wx`  in  10  write column.
- `update_wy`  in  10  write row.
- `update_renable`  in  1  read strobe.
- `update_rx`  in  10  read column.
- `update_ry`  in  10  read row.
- `update_rdata`  out  2  registered read data.
- `vga_hs`  out  1  horizontal sync, active-low.
- `vga_vs`  out  1  vertical sync, active-low.
- `vga_blank_n`  out  1  high inside the visible area.
- `vga_sync_n`  out  1  tied 0.
- `vga_clk`  out  1  pixel-enable toggle, drives the DAC clock.
- `vga_r`  out  8  red.
- `vga_g`  out  8  green.
- `vga_b`  out  8  blue.

## Operation
- **Storage**
  - MAPA_WIDTH·MAPA_HEIGHT × 2-bit array, addressed `y*MAPA_WIDTH + x`.
  - Contents are not cleared by reset. `update` repaints the grid in its own reset sweep.
- **Write**
  - When `update_wenable`=1, the cell is updated at that clk edge.
  - A write with `update_wx`≥MAPA_WIDTH or `update_wy`≥MAPA_HEIGHT is ignored.
- **Read**
  - When `update_renable`=1, `update_rdata` shows the cell value on the next edge.
  - When `update_renable`=0, `update_rdata` holds its last value.
  - An out-of-range read returns 00.
  - A read and a write to the same cell in the same cycle return the old value (read-before-write).
- **Pixel enable**
  - `pix_en` toggles every clk. Raster counters advance only when `pix_en`=1.
  - `vga_clk` = `pix_en`.
- **Horizontal counter `hc`** (0..799)
  - Visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- **Vertical counter `vc`** (0..524)
  - Visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
  - `vc` increments when `hc` wraps 799→0. `vc` wraps 524→0.
- **Tile lookup**
  - Tile address is `hc[9:4]`, `vc[8:4]`.
  - Scanout uses a second, independent memory read port. The scan path never stalls and never blocks `update` accesses.
- **Colour map**
  - 00 → black, 000000.
  - 01 → green, 00FF00.
  - 10 → red, FF0000.
  - 11 → grey, 808080.
  - Outside the visible area the RGB output is forced to 000000.
- **Raster state machine**
  - H states: ACTIVE, FRONT, SYNC, BACK. Each transition happens at the counter bounds listed above.
  - V states follow the same four-state pattern.
  - `vga_hs` is low only in H SYNC. `vga_vs` is low only in V SYNC.

## Timing
- **Reset values**
  - `hc`=0, `vc`=0, `pix_en`=0.
  - `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0.
  - RGB=0, `update_rdata`=00, `vga_sync_n`=0.
- Write latency: a cell written at edge N is visible to an `update` read issued at N+1 or later.
- Write-to-screen latency: the change appears when the raster next reaches that tile. This is at most one frame (420 000 pixels).
- **Scanout pipeline** (two pixel ticks)
  - Tick 1: address is registered and the memory is read.
  - Tick 2: the colour is registered.
  - `vga_hs`, `vga_vs` and `vga_blank_n` are delayed by the same two ticks, so they stay aligned with RGB.
- Mid-frame reset: all outputs go to their reset values immediately. After reset releases, the raster restarts at `hc`=0, `vc`=0, and the first full frame is valid.
- Frame period: 800·525·2 = 840 000 clk.

## Configuration
- `MAPA_GRID_LINES_EN` defined:
  - The visible pixel is drawn as 202020 when `hc[3:0]`==0 or `vc[3:0]`==0.
  - This applies only if the cell is 00. Non-empty tiles draw unchanged.
- `MAPA_GRID_LINES_EN` undefined: plain colour map only. Logic is identical otherwise.

## Test plan
- Reset release: count clk between `vga_vs` falling edges → 840 000; `vga_hs` low width → 192 clk; `vga_blank_n` high 1280 of every 1600 clk.
- Write (5,3)=10, then read with `update_renable` at (5,3) → `update_rdata`=10 on the next cycle. A simultaneous write of 01 to the same cell still returns 10 that cycle and 01 on the next read.
- Write (41,3)=11, then read (41,3) → 00. Cells (1,3) and (9,4) are unchanged.
- Write (0,0)=01 and (39,29)=11 → pixels `hc`=0..15, `vc`=0..15 show 00FF00; pixels `hc`=624..639, `vc`=464..479 show 808080; both aligned with `vga_blank_n` (no off-by-two).
- Assert reset mid-line at `hc`≈300 → outputs take their reset values within the same cycle. After release, the first `vga_hs` falls at pixel 656, with `vc`=0.
- With `MAPA_GRID_LINES_EN`: empty tile (2,2) → pixel (32,40) reads 202020; snake tile (3,2) → pixel (48,32) reads 00FF00.
